// File: rtl/edge_emitter_pkg.sv
// Shared constants and FSM encoding for the edge_emitter block.
// Optional overflow flag is controlled by EDGE_EMITTER_OVF_EN.
package edge_emitter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } state_e;

  localparam int unsigned DEF_MIN_GAP = 2;
  localparam int unsigned DEF_CNT_W   = 4;
  // Wide enough for the largest legal MIN_GAP-1 (254).
  localparam int unsigned GAP_W       = 8;

endpackage

// File: rtl/edge_gap_timer.sv
// Down-counter enforcing the minimum spacing between sig transitions.
// zero marks terminal count; expire flags the last nonzero cycle for FSM lookahead.
module edge_gap_timer
  import edge_emitter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [GAP_W-1:0] value,
  output logic             zero,
  output logic             expire
);

  logic [GAP_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero   = (cnt_q == '0);
  assign expire = (cnt_q == GAP_W'(1));

endmodule

// File: rtl/edge_emitter.sv
// Turns request pulses into sig transitions spaced at least MIN_GAP cycles apart.
// Define EDGE_EMITTER_OVF_EN to add the sticky ovf flag and its ovf_clr input.
//
//   state | meaning
//   IDLE  | gap timer expired, nothing pending
//   GAP   | gap timer running or requests pending
module edge_emitter
  import edge_emitter_pkg::*;
#(
  parameter int unsigned MIN_GAP = DEF_MIN_GAP,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  output logic             sig,
  output logic             busy,
  output logic [CNT_W-1:0] pending
`ifdef EDGE_EMITTER_OVF_EN
  ,
  output logic             ovf,
  input  logic             ovf_clr
`endif
);

  localparam logic [CNT_W-1:0] PMAX     = '1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 1);
  localparam bit               GAP_EN   = (MIN_GAP > 1);

  state_e           state_q, state_d;
  logic             sig_q, sig_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             gap_zero, gap_expire;
  logic             emit, drop, gap_run_d;

  edge_gap_timer u_gap_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (emit),
    .value  (GAP_LOAD),
    .zero   (gap_zero),
    .expire (gap_expire)
  );

  assign emit = gap_zero && ((pend_q != '0) || req);
  assign drop = req && !emit && (pend_q == PMAX);

  always_comb begin
    pend_d = pend_q;
    if (req && !emit && !drop) begin
      pend_d = pend_q + 1'b1;
    end else if (!req && emit) begin
      pend_d = pend_q - 1'b1;
    end
  end

  // Look one cycle ahead so busy drops the cycle the timer reaches zero.
  assign gap_run_d = emit ? GAP_EN : (!gap_zero && !gap_expire);
  assign state_d   = (gap_run_d || (pend_d != '0)) ? GAP : IDLE;
  assign sig_d     = sig_q ^ emit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sig_q   <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      pend_q  <= pend_d;
    end
  end

  assign sig     = sig_q;
  assign busy    = (state_q == GAP);
  assign pending = pend_q;

`ifdef EDGE_EMITTER_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: doc/edge_emitter.md
EDGE_EMITTER -- requirements
Module: edge_emitter

Interface
REQ-001 SHALL have parameter MIN_GAP, default 2: minimum clk cycles between consecutive sig transitions (legal range 1..255).
REQ-002 SHALL have parameter CNT_W, default 4: width of pending-edge counter; saturation value PMAX = 2^CNT_W-1.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have port req  input  1  edge request, sampled each posedge; each sampled 1 requests one sig transition.
REQ-006 SHALL have port sig  output  1  generated level; every transition represents one request.
REQ-007 SHALL have port busy  output  1  high while pending != 0 or gap timer != 0.
REQ-008 SHALL have port pending  output  CNT_W  number of accepted, not yet emitted requests.
REQ-009 SHALL have port ovf  output  1  sticky overflow flag (present only per REQ-027).
REQ-010 SHALL have port ovf_clr  input  1  synchronous clear of ovf (present only per REQ-027).

Function
REQ-011 SHALL emit (toggle sig) at a posedge iff gap == 0 and (pending > 0 or req == 1).
REQ-012 SHALL, from idle with gap == 0 and pending == 0, toggle sig on the same posedge that samples req = 1 (one-cycle latency, pending stays 0).
REQ-013 SHALL load gap with MIN_GAP-1 on every emission and decrement it by 1 each posedge while nonzero.
REQ-014 SHALL guarantee consecutive sig transitions are >= MIN_GAP cycles apart; with MIN_GAP = 1 sig may toggle every cycle.
REQ-015 SHALL update pending_next = pending + req - emit, where emit is 1 on emission cycles.
REQ-016 SHALL, on simultaneous req and emission with pending > 0, leave pending unchanged.
REQ-017 SHALL saturate pending at PMAX: req with pending == PMAX and no emission is dropped.
REQ-018 SHALL never underflow pending; emission with pending == 0 consumes the same-cycle req only.
REQ-019 SHALL implement FSM states IDLE (gap == 0, pending == 0) and GAP (gap != 0 or pending != 0); IDLE->GAP on emission; GAP->IDLE when gap reaches 0 and pending == 0 with no req.
REQ-020 SHALL drive busy = (state == GAP) combinationally from registers; no combinational path from req to sig, busy, or pending.
REQ-021 SHALL emit exactly N transitions for N accepted requests, so final sig = initial sig XOR (N mod 2).

Reset
REQ-022 SHALL, while reset = 0, force sig = 0, pending = 0, gap = 0, state = IDLE, busy = 0, ovf = 0, independent of clk.
REQ-023 SHALL discard all pending requests and any running gap on reset asserted mid-operation.
REQ-024 SHALL ignore req on the first posedge at which reset is released only if reset deasserts within setup of that edge; otherwise req is processed normally.

Configuration
REQ-025 SHALL use macro EDGE_EMITTER_OVF_EN to compile the overflow feature in or out.
REQ-026 SHALL, with EDGE_EMITTER_OVF_EN defined, set ovf on any posedge dropping a req per REQ-017; ovf_clr = 1 clears it, and set takes priority over clear in the same cycle.
REQ-027 SHALL, without EDGE_EMITTER_OVF_EN, omit the ovf and ovf_clr ports and their register; all other behaviour is identical.

Structure
REQ-028 SHALL place the FSM state encoding (IDLE, GAP) and the default MIN_GAP and CNT_W constants in shared package edge_emitter_pkg.
REQ-029 SHALL implement the gap countdown as sub-module edge_gap_timer (inputs load, value; output zero), instantiated once.

Verification
REQ-030 SHALL cover: MIN_GAP=2, single req pulse at cycle 5 -> sig 0->1 at edge 5, busy high for 1 cycle, pending stays 0.
REQ-031 SHALL cover: MIN_GAP=2, req held high 4 cycles from idle -> sig toggles at edges k, k+2, k+4, k+6; peak pending 2; final sig 0.
REQ-032 SHALL cover: CNT_W=3, MIN_GAP=4, req held 12 cycles -> pending saturates at 7, ovf set (OVF_EN), exactly 10 toggles total, sig returns to 0.
REQ-033 SHALL cover: reset pulled low with pending = 3 and gap = 1 -> all outputs 0 immediately without clk; after release, no toggles occur without req.
REQ-034 SHALL cover: MIN_GAP=1, req high every cycle for 5 cycles -> sig toggles every edge, pending stays 0, busy never asserted.
REQ-035 SHALL cover: ovf_clr and overflowing req on the same edge -> ovf remains 1; ovf_clr alone next cycle -> ovf 0.
